sgpr_busy_table_multiport: RTL and testbench
============================================

Name: sgpr_busy_table_multiport

Overview:
Registered scoreboard of scalar-register busy bits for the issue stage. One issue-side set port marks a contiguous run of up to MAX_WORDS SGPRs busy. NUM_CLR_PORTS writeback-side clear ports (SALU, LSU, ...) release runs. All runs wrap modulo NUM_SGPR. A combinational query port, a registered busy-count and a sticky double-set error flag support issue gating and debug.

Parameters:
NUM_SGPR, 104, number of tracked SGPRs; any value 8..256, need not be a power of two
ADDR_W, 7, SGPR address width; must satisfy 2**ADDR_W >= NUM_SGPR
MAX_WORDS, 4, maximum run length per port (1..8)
NUM_CLR_PORTS, 2, number of independent clear ports (1..4)
CNT_W, 8, busy-count width; must satisfy 2**CNT_W > NUM_SGPR

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous reset, active-low
set_addr  input  ADDR_W  first SGPR of the run to mark busy
set_valid  input  MAX_WORDS  bit i set -> SGPR (set_addr+i) mod NUM_SGPR marked busy
clr_addr  input  NUM_CLR_PORTS*ADDR_W  per-port first SGPR, port k at bits [k*ADDR_W +: ADDR_W]
clr_valid  input  NUM_CLR_PORTS*MAX_WORDS  per-port word mask, port k at bits [k*MAX_WORDS +: MAX_WORDS]
query_addr  input  ADDR_W  first SGPR of the run to check
query_valid  input  MAX_WORDS  word mask for the query run
query_busy  output  1  combinational: any queried SGPR busy in the current table
busy_table  output  NUM_SGPR  registered busy bits
busy_count  output  CNT_W  registered population count of busy_table
double_set_err  output  1  sticky: a set targeted an already-busy SGPR

Behaviour:
- Reset (rst low, asynchronous): busy_table=0, busy_count=0, double_set_err=0. Outputs stay at these values while rst is low. An assertion mid-operation discards all pending set/clear without partial update.
- Run decode, shared by set/clr/query ports: mask bit (addr+i) mod NUM_SGPR = valid[i]. Wrap is a true modulo: for addr+i >= NUM_SGPR, subtract NUM_SGPR. No shift-and-fold into the low 4 bits. An all-zero valid gives an all-zero mask regardless of addr.
- Out-of-range addr (addr >= NUM_SGPR): the port's mask is forced to zero (ignored). Not an error.
- Next state: busy_next = (busy_table & ~clr_mask_all) | set_mask. clr_mask_all is the OR of all clear-port masks.
- Precedence: when set and clear hit the same SGPR in the same cycle, set wins and the bit stays/becomes busy. Overlapping clear ports are idempotent.
- Latency: set/clear are visible on busy_table one cycle after the sampling edge. busy_count tracks busy_table in the same cycle, i.e. popcount of the registered table, registered alongside it.
- query_busy = |(busy_table & query_mask), purely combinational from the registered table. It does not see same-cycle set/clear (no bypass).
- double_set_err: set to 1 on the edge where (set_mask & busy_table & ~clr_mask_all) != 0. A bit cleared and set in the same cycle is not an error. The flag stays 1 until reset.
- No back-pressure: every port is accepted every cycle.
- Self-overlapping runs are impossible because MAX_WORDS <= NUM_SGPR.

Test Plan:
1. Reset then idle -> busy_table=0, busy_count=0, query_busy=0, double_set_err=0. Assert rst low mid-run after setting 12 bits -> all outputs return to 0 asynchronously, before the next clock edge.
2. set_addr=8, set_valid=4'b1111 -> next cycle bits 8..11 set, busy_count=4. Query addr=10, valid=4'b0001 -> query_busy=1. Query addr=12 -> query_busy=0.
3. Wrap: NUM_SGPR=104, set_addr=102, set_valid=4'b1111 -> bits 102,103,0,1 set, busy_count=4. Bits 104..127 do not exist and no other bit changes.
4. Simultaneous: table holds bits 8..11; same cycle set addr=10 valid=4'b0011 and clr port0 addr=8 valid=4'b1111 -> bits 10,11 remain, 8,9 cleared, busy_count=2, double_set_err stays 0.
5. Double set: bit 20 busy, set addr=20 valid=4'b0001 with no clear -> double_set_err=1 next cycle. It stays 1 after bit 20 is later cleared.
6. Multi-port clear: bits 0..7 busy; port0 addr=0 valid=4'b0101, port1 addr=4 valid=4'b1111 -> remaining bits 1,3, busy_count=2. Port addr=110 (out of range) valid=4'b1111 -> no change.

Source files
------------

// File: rtl/sgpr_busy_table_multiport_if.sv
// Bus bundle for the SGPR busy-table scoreboard: one set port, a group of
// clear ports, a query port and the registered status outputs.
interface sgpr_busy_table_multiport_if #(
  parameter int NUM_SGPR      = 104,
  parameter int ADDR_W        = 7,
  parameter int MAX_WORDS     = 4,
  parameter int NUM_CLR_PORTS = 2,
  parameter int CNT_W         = 8
);
  logic [ADDR_W-1:0]                  set_addr;
  logic [MAX_WORDS-1:0]               set_valid;
  logic [NUM_CLR_PORTS*ADDR_W-1:0]    clr_addr;
  logic [NUM_CLR_PORTS*MAX_WORDS-1:0] clr_valid;
  logic [ADDR_W-1:0]                  query_addr;
  logic [MAX_WORDS-1:0]               query_valid;
  logic                               query_busy;
  logic [NUM_SGPR-1:0]                busy_table;
  logic [CNT_W-1:0]                   busy_count;
  logic                               double_set_err;

  // Issue/writeback side driving the scoreboard
  modport master (
    output set_addr, set_valid, clr_addr, clr_valid, query_addr, query_valid,
    input  query_busy, busy_table, busy_count, double_set_err
  );

  // The scoreboard itself
  modport slave (
    input  set_addr, set_valid, clr_addr, clr_valid, query_addr, query_valid,
    output query_busy, busy_table, busy_count, double_set_err
  );
endinterface

// File: rtl/sgpr_busy_table_multiport.sv
// Scalar-register busy scoreboard. A set port marks a contiguous run of SGPRs
// busy, several clear ports release runs, and a combinational query port
// reports whether any SGPR of a run is busy. Runs wrap modulo NUM_SGPR; an
// out-of-range start address disables that port for the cycle.
module sgpr_busy_table_multiport #(
  parameter int NUM_SGPR      = 104,
  parameter int ADDR_W        = 7,
  parameter int MAX_WORDS     = 4,
  parameter int NUM_CLR_PORTS = 2,
  parameter int CNT_W         = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  sgpr_busy_table_multiport_if.slave      bus
);
  // One extra bit so addr+word never overflows before the modulo fold
  localparam int IW        = ADDR_W + 1;
  // Decoder slots: 0 = set, 1 = query, 2.. = clear ports
  localparam int NUM_PORTS = NUM_CLR_PORTS + 2;
  localparam int CLR_BASE  = 2;

  logic [NUM_PORTS-1:0][ADDR_W-1:0]    port_addr;
  logic [NUM_PORTS-1:0][MAX_WORDS-1:0] port_valid;
  logic [NUM_PORTS-1:0][NUM_SGPR-1:0]  port_mask;

  logic [NUM_SGPR-1:0] set_mask;
  logic [NUM_SGPR-1:0] query_mask;
  logic [NUM_SGPR-1:0] clr_mask_all;

  logic [NUM_SGPR-1:0] busy_table_reg;
  logic [NUM_SGPR-1:0] busy_table_next;
  logic [CNT_W-1:0]    busy_count_reg;
  logic [CNT_W-1:0]    busy_count_next;
  logic                double_set_err_reg;
  logic                double_set_err_next;

  assign port_addr[0]  = bus.set_addr;
  assign port_valid[0] = bus.set_valid;
  assign port_addr[1]  = bus.query_addr;
  assign port_valid[1] = bus.query_valid;

  genvar gi, gw, gb;

  generate
    for (gi = 0; gi < NUM_CLR_PORTS; gi++) begin : g_clr_unpack
      assign port_addr[CLR_BASE+gi]  = bus.clr_addr[gi*ADDR_W +: ADDR_W];
      assign port_valid[CLR_BASE+gi] = bus.clr_valid[gi*MAX_WORDS +: MAX_WORDS];
    end
  endgenerate

  // Shared run decoder: word i of a port lands on (addr+i) mod NUM_SGPR.
  // A single conditional subtract is a true modulo because the run is never
  // longer than the table.
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic                            in_range;
      logic [MAX_WORDS-1:0][IW-1:0]    word_idx;

      assign in_range = ({1'b0, port_addr[gi]} < IW'(NUM_SGPR));

      for (gw = 0; gw < MAX_WORDS; gw++) begin : g_word
        logic [IW-1:0] raw_idx;
        assign raw_idx      = {1'b0, port_addr[gi]} + IW'(gw);
        assign word_idx[gw] = (raw_idx >= IW'(NUM_SGPR)) ? (raw_idx - IW'(NUM_SGPR)) : raw_idx;
      end

      for (gb = 0; gb < NUM_SGPR; gb++) begin : g_bit
        logic [MAX_WORDS-1:0] hit;
        for (gw = 0; gw < MAX_WORDS; gw++) begin : g_hit
          assign hit[gw] = port_valid[gi][gw] && (word_idx[gw] == IW'(gb));
        end
        assign port_mask[gi][gb] = in_range && (|hit);
      end
    end
  endgenerate

  assign set_mask   = port_mask[0];
  assign query_mask = port_mask[1];

  // Union of all clear ports; overlapping clears simply merge
  always_comb begin
    clr_mask_all = '0;
    for (int p = 0; p < NUM_CLR_PORTS; p++) begin
      clr_mask_all = clr_mask_all | port_mask[CLR_BASE+p];
    end
  end

  // Next table (set beats clear), its popcount and the sticky double-set flag
  always_comb begin
    busy_table_next = (busy_table_reg & ~clr_mask_all) | set_mask;
    busy_count_next = '0;
    for (int b = 0; b < NUM_SGPR; b++) begin
      busy_count_next = busy_count_next + CNT_W'(busy_table_next[b]);
    end
    double_set_err_next = double_set_err_reg |
                          (|(set_mask & busy_table_reg & ~clr_mask_all));
  end

  // State registers; reset drops everything, including pending updates
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_table_reg     <= '0;
      busy_count_reg     <= '0;
      double_set_err_reg <= 1'b0;
    end else begin
      busy_table_reg     <= busy_table_next;
      busy_count_reg     <= busy_count_next;
      double_set_err_reg <= double_set_err_next;
    end
  end

  assign bus.busy_table     = busy_table_reg;
  assign bus.busy_count     = busy_count_reg;
  assign bus.double_set_err = double_set_err_reg;
  // Looks only at the registered table: no same-cycle bypass
  assign bus.query_busy     = |(busy_table_reg & query_mask);

endmodule

// File: tb/tb_sgpr_busy_table_multiport.sv
// Directed bench for the SGPR busy-table scoreboard (default parameters).
module tb_sgpr_busy_table_multiport;
  localparam int NUM_SGPR      = 104;
  localparam int ADDR_W        = 7;
  localparam int MAX_WORDS     = 4;
  localparam int NUM_CLR_PORTS = 2;
  localparam int CNT_W         = 8;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  logic [NUM_SGPR-1:0] exp_tab;

  sgpr_busy_table_multiport_if #(
    .NUM_SGPR(NUM_SGPR), .ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS),
    .NUM_CLR_PORTS(NUM_CLR_PORTS), .CNT_W(CNT_W)
  ) bus ();

  sgpr_busy_table_multiport #(
    .NUM_SGPR(NUM_SGPR), .ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS),
    .NUM_CLR_PORTS(NUM_CLR_PORTS), .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.set_addr    = '0;
    bus.set_valid   = '0;
    bus.clr_addr    = '0;
    bus.clr_valid   = '0;
    bus.query_addr  = '0;
    bus.query_valid = '0;
  endtask

  // Advance one clock and land 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_run(input int addr, input logic [3:0] valid);
    bus.set_addr  = ADDR_W'(addr);
    bus.set_valid = valid;
  endtask

  task automatic clr_run(input int port, input int addr, input logic [3:0] valid);
    bus.clr_addr[port*ADDR_W +: ADDR_W]       = ADDR_W'(addr);
    bus.clr_valid[port*MAX_WORDS +: MAX_WORDS] = valid;
  endtask

  task automatic query(input int addr, input logic [3:0] valid);
    bus.query_addr  = ADDR_W'(addr);
    bus.query_valid = valid;
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b0;
    idle();
    repeat (2) step();

    // 1. Reset state, then release and idle
    check("rst_table", bus.busy_table, '0);
    rst = 1'b1;
    step();
    step();
    check("idle_table", bus.busy_table, '0);
    check("idle_count", bus.busy_count, 0);
    check("idle_query", bus.query_busy, 0);
    check("idle_err", bus.double_set_err, 0);

    // Fill 12 bits (40..51) then force a double set
    set_run(40, 4'b1111); step();
    set_run(44, 4'b1111); step();
    set_run(48, 4'b1111); step();
    idle();
    exp_tab = '0;
    for (int i = 40; i < 52; i++) exp_tab[i] = 1'b1;
    check("fill12_table", bus.busy_table, exp_tab);
    check("fill12_count", bus.busy_count, 12);
    set_run(40, 4'b0001); step();
    check("pre_rst_err", bus.double_set_err, 1);
    // Mid-cycle async reset with set/clear still pending
    set_run(60, 4'b1111);
    clr_run(0, 40, 4'b1111);
    rst = 1'b0;
    #1;
    check("async_rst_table", bus.busy_table, '0);
    check("async_rst_count", bus.busy_count, 0);
    check("async_rst_err", bus.double_set_err, 0);
    step();
    check("held_rst_table", bus.busy_table, '0);
    idle();
    rst = 1'b1;
    step();

    // 2. Basic set and query
    set_run(8, 4'b1111); step(); idle();
    check("set8_table", bus.busy_table, 104'hF00);
    check("set8_count", bus.busy_count, 4);
    query(10, 4'b0001);
    check("q10", bus.query_busy, 1);
    query(12, 4'b0001);
    check("q12", bus.query_busy, 0);
    query(7, 4'b1000);
    check("q7_w3", bus.query_busy, 1);
    query(103, 4'b0010);
    check("q103_wrap_free", bus.query_busy, 0);

    // 4. Same-cycle set and clear: set wins, no error
    set_run(10, 4'b0011);
    clr_run(0, 8, 4'b1111);
    step(); idle();
    check("simul_table", bus.busy_table, 104'hC00);
    check("simul_count", bus.busy_count, 2);
    check("simul_err", bus.double_set_err, 0);
    clr_run(0, 10, 4'b0011); step(); idle();
    check("clr_all_table", bus.busy_table, '0);

    // 3. Wrap at the top of the table
    set_run(102, 4'b1111); step(); idle();
    exp_tab = '0;
    exp_tab[102] = 1'b1; exp_tab[103] = 1'b1; exp_tab[0] = 1'b1; exp_tab[1] = 1'b1;
    check("wrap_table", bus.busy_table, exp_tab);
    check("wrap_count", bus.busy_count, 4);
    query(103, 4'b0100);
    check("q_wrap", bus.query_busy, 1);
    idle();
    // Wrapping clear on port 1: bits 0,1,2
    clr_run(1, 103, 4'b1110); step(); idle();
    exp_tab = '0;
    exp_tab[102] = 1'b1; exp_tab[103] = 1'b1;
    check("wrap_clr_table", bus.busy_table, exp_tab);
    check("wrap_clr_count", bus.busy_count, 2);
    clr_run(0, 102, 4'b0011); step(); idle();
    check("wrap_empty", bus.busy_table, '0);

    // 5. Double set is sticky
    set_run(20, 4'b0001); step(); idle();
    check("b20_count", bus.busy_count, 1);
    check("b20_err0", bus.double_set_err, 0);
    set_run(20, 4'b0001); step(); idle();
    check("dbl_err", bus.double_set_err, 1);
    check("dbl_table", bus.busy_table, 104'h100000);
    clr_run(0, 20, 4'b0001); step(); idle();
    check("dbl_clr_table", bus.busy_table, '0);
    check("dbl_sticky", bus.double_set_err, 1);

    // 6. Multi-port clear and out-of-range ports
    set_run(0, 4'b1111); step();
    set_run(4, 4'b1111); step(); idle();
    check("fill8_table", bus.busy_table, 104'hFF);
    check("fill8_count", bus.busy_count, 8);
    clr_run(0, 0, 4'b0101);
    clr_run(1, 4, 4'b1111);
    step(); idle();
    check("mclr_table", bus.busy_table, 104'hA);
    check("mclr_count", bus.busy_count, 2);
    clr_run(0, 110, 4'b1111);
    clr_run(1, 127, 4'b1111);
    set_run(110, 4'b1111);
    step(); idle();
    check("oor_table", bus.busy_table, 104'hA);
    check("oor_count", bus.busy_count, 2);
    query(110, 4'b1111);
    check("oor_query", bus.query_busy, 0);
    query(0, 4'b1000);
    check("q3_busy", bus.query_busy, 1);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
